// File: rtl/axi_defines_pkg.sv
// Shared AXI read-channel types used by the slave and its address generator.
// Burst-level legality lives here so every consumer agrees on what is an error.
package axi_defines;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    burst_t      burst;
  } ar_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    resp_t       resp;
    logic        last;
  } r_t;

  function automatic logic burst_err(
    input logic [7:0] len,
    input logic [2:0] size,
    input burst_t     burst
  );
    logic wlen_ok;
    wlen_ok = (len == 8'd1) || (len == 8'd3) ||
              (len == 8'd7) || (len == 8'd15);
    return (size > 3'd2) ||
           (burst == BURST_RSVD) ||
           ((burst == BURST_WRAP) && !wlen_ok);
  endfunction

endpackage

// File: rtl/axi_read_slave_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
// WRAP assumes a legal length; illegal bursts never reach memory anyway.
module axi_addr_gen
  import axi_defines::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [7:0]  len,
  input  burst_t      burst,
  output logic [31:0] next_addr
);

  logic [31:0] bytes;
  logic [31:0] wsize;
  logic [31:0] wmask;

  always_comb begin
    bytes     = 32'd1 << size;
    wsize     = ({24'd0, len} + 32'd1) << size;
    wmask     = wsize - 32'd1;
    next_addr = addr;
    unique case (1'b1)
      (burst == BURST_INCR):
        next_addr = (addr & ~(bytes - 32'd1)) + bytes;
      (burst == BURST_WRAP):
        next_addr = (addr & ~wmask) | ((addr + bytes) & wmask);
      default:
        next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_read_slave.sv
// Single-outstanding AXI read slave over a 1-cycle-latency word memory.
// One beat every three cycles: ISSUE -> WAIT -> RESP.
module axi_read_slave
  import axi_defines::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  ar_t         ar,
  output logic        ar_ready,
  output r_t          r,
  input  logic        r_ready,
  output logic        mem_re,
  output logic [29:0] mem_addr,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [31:0] LIMIT = 32'(MEM_BYTES);

  state_t      state;
  logic [31:0] cur_addr;
  logic [31:0] next_addr;
  logic [7:0]  len;
  logic [7:0]  beat;
  logic [2:0]  size;
  burst_t      burst;
  logic        slverr;
  logic        decerr;

  logic        ar_bad;
  logic        ar_oor;
  logic        nx_oor;

  axi_addr_gen u_gen (
    .addr      (cur_addr),
    .size      (size),
    .len       (len),
    .burst     (burst),
    .next_addr (next_addr)
  );

  assign ar_bad = burst_err(ar.len, ar.size, ar.burst);
  assign ar_oor = ar.addr >= LIMIT;
  assign nx_oor = next_addr >= LIMIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ar_ready <= 1'b1;
      r        <= '0;
      mem_re   <= 1'b0;
      mem_addr <= '0;
      cur_addr <= '0;
      len      <= '0;
      beat     <= '0;
      size     <= '0;
      burst    <= BURST_FIXED;
      slverr   <= 1'b0;
      decerr   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ar.valid) begin
            cur_addr <= ar.addr;
            len      <= ar.len;
            size     <= ar.size;
            burst    <= ar.burst;
            beat     <= '0;
            slverr   <= ar_bad;
            decerr   <= ar_oor;
            mem_re   <= !ar_bad && !ar_oor;
            mem_addr <= ar.addr[31:2];
            ar_ready <= 1'b0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          mem_re <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          r.valid <= 1'b1;
          r.data  <= (slverr || decerr) ? 32'd0 : mem_rdata;
          r.last  <= beat == len;
          if (slverr)
            r.resp <= RESP_SLVERR;
          else if (decerr)
            r.resp <= RESP_DECERR;
          else
            r.resp <= RESP_OKAY;
          state <= RESP;
        end
        RESP: begin
          if (r_ready) begin
            r.valid <= 1'b0;
            r.last  <= 1'b0;
            if (r.last) begin
              ar_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              beat     <= beat + 8'd1;
              cur_addr <= next_addr;
              decerr   <= nx_oor;
              mem_re   <= !slverr && !nx_oor;
              mem_addr <= next_addr[31:2];
              state    <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
